// File: rtl/sram_loader_pkg.sv
// Shared definitions for sram_loader: opcodes, response codes, FSM state encodings and a
// byte-shift helper. Optional feature macro: LOADER_AUTOINC_EN (see sram_loader.sv).
package sram_loader_pkg;

  // Command opcodes
  localparam logic [7:0] OpWrite   = 8'h57;
  localparam logic [7:0] OpRead    = 8'h52;
  localparam logic [7:0] OpAutoinc = 8'h4E;

  // Response codes
  localparam logic [7:0] RspOk      = 8'h4B;
  localparam logic [7:0] RspTimeout = 8'h54;
  localparam logic [7:0] RspErr     = 8'h3F;

  // FSM state encodings
  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StAddr = 3'd1;
  localparam logic [2:0] StData = 3'd2;
  localparam logic [2:0] StReq  = 3'd3;
  localparam logic [2:0] StResp = 3'd4;
  localparam logic [2:0] StErr  = 3'd5;

  // Append a byte at the LSB end; fields arrive MSB first.
  function automatic logic [31:0] shift_in(logic [31:0] v, logic [7:0] b);
    return {v[23:0], b};
  endfunction

endpackage

// File: rtl/loader_timer.sv
// Loadable down-counter for the memory-request timeout. While i_load is high the counter is
// held at TIMEOUT_CYC-1; while i_en is high it counts down and o_expired flags the last cycle.
module loader_timer #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [15:0] LoadVal = 16'(TIMEOUT_CYC - 1);

  logic [15:0] r_count;

  // Reload outside the request phase, count down during it, stop at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= LoadVal;
    end else if (i_load) begin
      r_count <= LoadVal;
    end else if (i_en && (r_count != 16'd0)) begin
      r_count <= r_count - 16'd1;
    end
  end

  assign o_expired = i_en && (r_count == 16'd0);

endmodule

// File: rtl/sram_loader.sv
// Byte-stream command loader driving a single-outstanding SRAM request port.
// Commands: 0x57 write (address + 4 data bytes), 0x52 read (address); MSB first.
// Optional feature macro LOADER_AUTOINC_EN enables opcode 0x4E (write 4 data bytes to the
// previous request address + 4); without it 0x4E is an unknown opcode.
module sram_loader
  import sram_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned ADDR_BYTES  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        stb,
  output logic        rw,
  output logic [31:0] addr,
  output logic [31:0] dtw,
  input  logic        ack,
  input  logic [31:0] dtr,
  output logic        busy
);

  localparam logic [2:0] AddrLast = 3'(ADDR_BYTES - 1);

  logic [2:0]  r_state;
  logic        r_ready_en;
  logic [2:0]  r_cnt;
  logic        r_rw;
  logic [31:0] r_addr;
  logic [31:0] r_dtw;
  logic [31:0] r_resp;
  logic [2:0]  r_left;

  logic [2:0]  w_state_d;
  logic [2:0]  w_cnt_d;
  logic        w_rw_d;
  logic [31:0] w_addr_d;
  logic [31:0] w_dtw_d;
  logic [31:0] w_resp_d;
  logic [2:0]  w_left_d;

  logic w_rx_fire;
  logic w_tx_fire;
  logic w_in_req;
  logic w_expired;

  assign w_in_req  = (r_state == StReq);
  assign w_rx_fire = rx_valid && rx_ready;
  assign w_tx_fire = tx_valid && tx_ready;

  loader_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (!w_in_req),
    .i_en     (w_in_req),
    .o_expired(w_expired)
  );

  // Next-state and datapath updates for the command FSM.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_rw_d    = r_rw;
    w_addr_d  = r_addr;
    w_dtw_d   = r_dtw;
    w_resp_d  = r_resp;
    w_left_d  = r_left;
    case (r_state)
      StIdle: begin
        if (w_rx_fire) begin
          if ((rx_data == OpWrite) || (rx_data == OpRead)) begin
            w_state_d = StAddr;
            w_cnt_d   = 3'd0;
            w_rw_d    = (rx_data == OpWrite);
            // Cleared so that unsent upper address bytes read as zero.
            w_addr_d  = 32'd0;
          end
`ifdef LOADER_AUTOINC_EN
          else if (rx_data == OpAutoinc) begin
            w_state_d = StData;
            w_cnt_d   = 3'd0;
            w_rw_d    = 1'b1;
            w_addr_d  = r_addr + 32'd4;
          end
`endif
          else begin
            w_state_d = StErr;
          end
        end
      end
      StAddr: begin
        if (w_rx_fire) begin
          w_addr_d = shift_in(r_addr, rx_data);
          if (r_cnt == AddrLast) begin
            w_cnt_d   = 3'd0;
            w_state_d = r_rw ? StData : StReq;
          end else begin
            w_cnt_d = r_cnt + 3'd1;
          end
        end
      end
      StData: begin
        if (w_rx_fire) begin
          w_dtw_d = shift_in(r_dtw, rx_data);
          if (r_cnt == 3'd3) begin
            w_cnt_d   = 3'd0;
            w_state_d = StReq;
          end else begin
            w_cnt_d = r_cnt + 3'd1;
          end
        end
      end
      StReq: begin
        // Ack wins over a coincident timeout expiry.
        if (ack) begin
          w_state_d = StResp;
          if (r_rw) begin
            w_resp_d = {RspOk, 24'd0};
            w_left_d = 3'd1;
          end else begin
            w_resp_d = dtr;
            w_left_d = 3'd4;
          end
        end else if (w_expired) begin
          w_state_d = StResp;
          w_resp_d  = {RspTimeout, 24'd0};
          w_left_d  = 3'd1;
        end
      end
      StResp: begin
        if (w_tx_fire) begin
          w_resp_d = {r_resp[23:0], 8'd0};
          w_left_d = r_left - 3'd1;
          if (r_left == 3'd1) begin
            w_state_d = StIdle;
          end
        end
      end
      StErr: begin
        if (w_tx_fire) begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset clears every externally visible value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_ready_en <= 1'b0;
      r_cnt      <= 3'd0;
      r_rw       <= 1'b0;
      r_addr     <= 32'd0;
      r_dtw      <= 32'd0;
      r_resp     <= 32'd0;
      r_left     <= 3'd0;
    end else begin
      r_state    <= w_state_d;
      r_ready_en <= 1'b1;
      r_cnt      <= w_cnt_d;
      r_rw       <= w_rw_d;
      r_addr     <= w_addr_d;
      r_dtw      <= w_dtw_d;
      r_resp     <= w_resp_d;
      r_left     <= w_left_d;
    end
  end

  // Output decode from the registered state.
  always_comb begin
    rx_ready = r_ready_en &&
               ((r_state == StIdle) || (r_state == StAddr) || (r_state == StData));
    stb      = w_in_req;
    rw       = r_rw;
    addr     = r_addr;
    dtw      = r_dtw;
    busy     = (r_state != StIdle);
    tx_valid = (r_state == StResp) || (r_state == StErr);
    tx_data  = 8'd0;
    if (r_state == StResp) begin
      tx_data = r_resp[31:24];
    end else if (r_state == StErr) begin
      tx_data = RspErr;
    end
  end

endmodule
